// File: rtl/dmem_pkg.sv
// Shared constants, FSM state type and address/byte helpers for the
// byte-wide data-memory port arbiter.
package dmem_pkg;

  localparam int ADDR_W = 10;
  localparam int DATA_W = 32;
  localparam int BYTE_W = 8;
  localparam int BEATS  = DATA_W / BYTE_W;
  localparam int BEAT_W = $clog2(BEATS);

  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

  localparam logic PORT_MEM = 1'b0;
  localparam logic PORT_LDR = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BEAT  = 2'd1,
    DRAIN = 2'd2,
    RESP  = 2'd3
  } state_e;

  // Word at A spans bytes A-3 (MSB) .. A (LSB), wrapping modulo 2^ADDR_W.
  function automatic logic [ADDR_W-1:0] beat_addr(input logic [ADDR_W-1:0] a,
                                                  input logic [BEAT_W-1:0] beat);
    return a - ADDR_W'(BEATS - 1) + ADDR_W'(beat);
  endfunction

  function automatic logic [BYTE_W-1:0] beat_byte(input logic [DATA_W-1:0] w,
                                                  input logic [BEAT_W-1:0] beat);
    return w[DATA_W-1-BYTE_W*int'(beat) -: BYTE_W];
  endfunction

endpackage

// File: rtl/dmem_word_assembler.sv
// Shifts read bytes in MSB first; word_o already includes the byte on byte_i,
// so the complete word is available in the cycle the last byte arrives.
module dmem_word_assembler
  import dmem_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              clr_i,
  input  logic              shift_i,
  input  logic [BYTE_W-1:0] byte_i,
  output logic [DATA_W-1:0] word_o
);

  logic [DATA_W-1:0] sh_q;

  assign word_o = {sh_q[DATA_W-BYTE_W-1:0], byte_i};

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sh_q <= '0;
    end else if (clr_i) begin
      sh_q <= '0;
    end else if (shift_i) begin
      sh_q <= word_o;
    end else begin
      sh_q <= sh_q;
    end
  end

endmodule

// File: rtl/dmem_port_arbiter.sv
// Round-robin arbiter sharing one byte-wide memory port between the MEM stage
// (port 0) and the loader (port 1); each word access is four MSB-first beats.
module dmem_port_arbiter
  import dmem_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req0_i,
  input  logic              req1_i,
  input  logic              we0_i,
  input  logic              we1_i,
  input  logic [31:0]       addr0_i,
  input  logic [31:0]       addr1_i,
  input  logic [DATA_W-1:0] wdata0_i,
  input  logic [DATA_W-1:0] wdata1_i,
  output logic              ack0_o,
  output logic              ack1_o,
  output logic [DATA_W-1:0] rdata_o,
  output logic              stall0_o,
  output logic              mem_en_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [BYTE_W-1:0] mem_wdata_o,
  input  logic [BYTE_W-1:0] mem_rdata_i
);

  state_e              state_q, state_d;
  logic [BEAT_W-1:0]   beat_q, beat_d;
  logic                port_q, port_d, port_sel_s;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                rr_last_q, rr_last_d;
  logic                grant_s;
  logic                ack0_q, ack0_d, ack1_q, ack1_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d, asm_word_s;
  logic                mem_en_q, mem_en_d, mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [BYTE_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic                cap_q;

  always_comb begin
    if (req0_i && req1_i) begin
      port_sel_s = ~rr_last_q;
    end else if (req1_i) begin
      port_sel_s = PORT_LDR;
    end else begin
      port_sel_s = PORT_MEM;
    end
  end

  always_comb begin
    state_d   = state_q;
    beat_d    = beat_q;
    port_d    = port_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rr_last_d = rr_last_q;
    grant_s   = 1'b0;
    case (state_q)
      IDLE: begin
        if (req0_i || req1_i) begin
          grant_s   = 1'b1;
          port_d    = port_sel_s;
          rr_last_d = port_sel_s;
          we_d      = (port_sel_s == PORT_LDR) ? we1_i : we0_i;
          addr_d    = (port_sel_s == PORT_LDR) ? addr1_i[ADDR_W-1:0] : addr0_i[ADDR_W-1:0];
          wdata_d   = (port_sel_s == PORT_LDR) ? wdata1_i : wdata0_i;
          beat_d    = '0;
          state_d   = BEAT;
        end else begin
          state_d = IDLE;
        end
      end
      BEAT: begin
        if (beat_q == LAST_BEAT) begin
          state_d = DRAIN;
        end else begin
          beat_d = beat_q + BEAT_W'(1);
        end
      end
      DRAIN:   state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are computed from next-state values so they can be registered
  // without adding a cycle to the beat/ack timing.
  always_comb begin
    mem_en_d    = (state_d == BEAT);
    mem_we_d    = mem_en_d & we_d;
    mem_addr_d  = mem_en_d ? beat_addr(addr_d, beat_d) : mem_addr_q;
    mem_wdata_d = mem_en_d ? beat_byte(wdata_d, beat_d) : mem_wdata_q;
    ack0_d      = (state_d == RESP) && (port_d == PORT_MEM);
    ack1_d      = (state_d == RESP) && (port_d == PORT_LDR);
    rdata_d     = ((state_d == RESP) && !we_d) ? asm_word_s : rdata_q;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      beat_q      <= '0;
      port_q      <= PORT_MEM;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rr_last_q   <= PORT_LDR;
      ack0_q      <= 1'b0;
      ack1_q      <= 1'b0;
      rdata_q     <= '0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      cap_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      beat_q      <= beat_d;
      port_q      <= port_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rr_last_q   <= rr_last_d;
      ack0_q      <= ack0_d;
      ack1_q      <= ack1_d;
      rdata_q     <= rdata_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      // Memory returns a read byte one cycle after its beat.
      cap_q       <= mem_en_q & ~mem_we_q;
    end
  end

  dmem_word_assembler u_asm (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .clr_i   (grant_s),
    .shift_i (cap_q),
    .byte_i  (mem_rdata_i),
    .word_o  (asm_word_s)
  );

  assign ack0_o      = ack0_q;
  assign ack1_o      = ack1_q;
  assign rdata_o     = rdata_q;
  assign stall0_o    = req0_i & ~ack0_q;
  assign mem_en_o    = mem_en_q;
  assign mem_we_o    = mem_we_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Bench for dmem_port_arbiter: byte RAM model, directed vector table,
// multi-cycle corner sequences and a randomized run against a word-level model.
module tb_dmem_port_arbiter;
  import dmem_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0, req1, we0, we1;
  logic [31:0] addr0, addr1, wdata0, wdata1;
  logic        ack0, ack1, stall0, mem_en, mem_we;
  logic [31:0] rdata;
  logic [9:0]  mem_addr;
  logic [7:0]  mem_wdata, mem_rdata;

  always #5 clk = ~clk;

  dmem_port_arbiter dut (
    .clk_i(clk), .rst_i(rst),
    .req0_i(req0), .req1_i(req1), .we0_i(we0), .we1_i(we1),
    .addr0_i(addr0), .addr1_i(addr1), .wdata0_i(wdata0), .wdata1_i(wdata1),
    .ack0_o(ack0), .ack1_o(ack1), .rdata_o(rdata), .stall0_o(stall0),
    .mem_en_o(mem_en), .mem_we_o(mem_we), .mem_addr_o(mem_addr),
    .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata)
  );

  bit [7:0] mem [1024];
  bit [7:0] ref_mem [1024];

  always @(posedge clk) begin
    if (mem_en && mem_we) mem[mem_addr] <= mem_wdata;
    if (mem_en && !mem_we) mem_rdata <= mem[mem_addr];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int c; int a; int d; } wr_t;
  wr_t wlog[$];
  always @(negedge clk) begin
    if (mem_en && mem_we) wlog.push_back('{cyc, int'(mem_addr), int'(mem_wdata)});
  end

  int n_pass = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  typedef struct {
    bit          port;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
  } vec_t;
  vec_t vecs[7];

  task automatic access(input bit port, input bit we, input logic [31:0] addr,
                        input logic [31:0] wdata, output int lat,
                        output logic [31:0] rd, output int t0, output bit hs_ok);
    @(negedge clk);
    t0 = cyc; lat = -1; rd = 32'hxxxx_xxxx; hs_ok = 1'b1;
    if (port) begin req1 = 1'b1; we1 = we; addr1 = addr; wdata1 = wdata; end
    else      begin req0 = 1'b1; we0 = we; addr0 = addr; wdata0 = wdata; end
    for (int n = 0; n < 20; n++) begin
      #1;
      if (port ? ack0 : ack1) hs_ok = 1'b0;
      if (port ? ack1 : ack0) begin
        lat = n; rd = rdata;
        break;
      end
      if (!port && !stall0) hs_ok = 1'b0;
      @(negedge clk);
    end
    req0 = 1'b0; req1 = 1'b0;
  endtask

  function automatic logic [31:0] ref_read(input logic [31:0] a);
    logic [31:0] w;
    for (int b = 0; b < 4; b++) w[31-8*b -: 8] = ref_mem[(int'(a[9:0]) - 3 + b) & 1023];
    return w;
  endfunction

  task automatic ref_write(input logic [31:0] a, input logic [31:0] d);
    for (int b = 0; b < 4; b++) ref_mem[(int'(a[9:0]) - 3 + b) & 1023] = d[31-8*b -: 8];
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int lat, t0, k, nexp, mism;
    bit hs_ok, both;
    logic [31:0] rd, last_rd;
    int ev_n[$];
    bit ev_p[$];
    bit sel0, sel1, last_g;
    bit order[2];
    bit rwe[2];
    logic [31:0] raddr[2], rdat[2];

    vecs[0] = '{1'b0, 1'b1, 32'h0000_0007, 32'h1122_3344, 32'h0};
    vecs[1] = '{1'b0, 1'b0, 32'h0000_0007, 32'h0,         32'h1122_3344};
    vecs[2] = '{1'b1, 1'b1, 32'h0000_0001, 32'hA1B2_C3D4, 32'h0};
    vecs[3] = '{1'b0, 1'b0, 32'h0000_0001, 32'h0,         32'hA1B2_C3D4};
    vecs[4] = '{1'b1, 1'b1, 32'hABCD_F3F0, 32'hCAFE_F00D, 32'h0};
    vecs[5] = '{1'b0, 1'b0, 32'h0000_03F0, 32'h0,         32'hCAFE_F00D};
    vecs[6] = '{1'b1, 1'b0, 32'h0000_0407, 32'h0,         32'h1122_3344};

    rst = 1'b1; req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
    addr0 = 32'h0; addr1 = 32'h0; wdata0 = 32'h0; wdata1 = 32'h0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_ack0", {31'd0, ack0}, 32'd0);
    check("rst_ack1", {31'd0, ack1}, 32'd0);
    check("rst_rdata", rdata, 32'd0);
    check("rst_mem_en_we", {30'd0, mem_en, mem_we}, 32'd0);
    check("rst_mem_addr_wdata", {14'd0, mem_addr, mem_wdata}, 32'd0);
    check("rst_stall0", {31'd0, stall0}, 32'd0);
    rst = 1'b0;

    // Both ports requesting from reset and held: 0,1,0,1 at 7-cycle spacing.
    @(negedge clk);
    t0 = cyc; both = 1'b0;
    req0 = 1'b1; we0 = 1'b1; addr0 = 32'd100; wdata0 = 32'h0101_0101;
    req1 = 1'b1; we1 = 1'b1; addr1 = 32'd200; wdata1 = 32'h0202_0202;
    for (int n = 0; n < 30; n++) begin
      #1;
      if (ack0 && ack1) both = 1'b1;
      if (ack0) begin ev_n.push_back(n); ev_p.push_back(1'b0); end
      if (ack1) begin ev_n.push_back(n); ev_p.push_back(1'b1); end
      @(negedge clk);
    end
    req0 = 1'b0; req1 = 1'b0;
    repeat (8) @(negedge clk);
    check("arb_no_dual_ack", {31'd0, both}, 32'd0);
    check("arb_ack_count", ev_n.size(), 32'd4);
    for (int i = 0; i < 4 && i < ev_n.size(); i++) begin
      check($sformatf("arb_grant%0d", i), {ev_n[i][30:0], ev_p[i]},
            {31'(6 + 7*i), 1'(i % 2)});
    end

    // Directed vector table.
    last_rd = 32'h0;
    for (int i = 0; i < 7; i++) begin
      wlog.delete();
      access(vecs[i].port, vecs[i].we, vecs[i].addr, vecs[i].wdata, lat, rd, t0, hs_ok);
      check($sformatf("vec%0d_latency", i), lat, 32'd6);
      check($sformatf("vec%0d_handshake", i), {31'd0, hs_ok}, 32'd1);
      if (vecs[i].we) begin
        check($sformatf("vec%0d_rdata_held", i), rd, last_rd);
      end else begin
        check($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rd);
        last_rd = vecs[i].exp_rd;
      end
      if (i == 0) begin
        check("w7_beats", wlog.size(), 32'd4);
        for (int b = 0; b < 4 && b < wlog.size(); b++) begin
          check($sformatf("w7_beat%0d", b),
                ((wlog[b].c - t0) << 24) | (wlog[b].a << 8) | wlog[b].d,
                ((b + 1) << 24) | ((4 + b) << 8) | int'(vecs[0].wdata[31-8*b -: 8]));
        end
      end
      if (i == 2) begin
        check("wrap_bytes", {mem[1022], mem[1023], mem[0], mem[1]}, 32'hA1B2_C3D4);
      end
    end

    // Loader drops req1 mid-access and scrambles its inputs.
    wlog.delete();
    @(negedge clk);
    t0 = cyc; lat = -1;
    req1 = 1'b1; we1 = 1'b1; addr1 = 32'd20; wdata1 = 32'h5566_7788;
    for (int n = 0; n < 20; n++) begin
      #1;
      if (n == 2) begin req1 = 1'b0; addr1 = 32'd3; wdata1 = 32'h0; we1 = 1'b0; end
      if (ack1) begin lat = n; break; end
      @(negedge clk);
    end
    check("drop_latency", lat, 32'd6);
    check("drop_beats", wlog.size(), 32'd4);
    @(negedge clk);
    check("drop_bytes", {mem[17], mem[18], mem[19], mem[20]}, 32'h5566_7788);

    // Reset during a write to A=11: only the first byte lands.
    @(negedge clk);
    t0 = cyc; k = 0;
    req0 = 1'b1; we0 = 1'b1; addr0 = 32'd11; wdata0 = 32'hDEAD_BEEF;
    @(negedge clk);
    rst = 1'b1; req0 = 1'b0;
    @(negedge clk);
    #1;
    check("abort_mem_en", {31'd0, mem_en}, 32'd0);
    check("abort_rdata", rdata, 32'd0);
    check("abort_mem_addr", {22'd0, mem_addr}, 32'd0);
    for (int n = 0; n < 10; n++) begin
      if (n == 2) rst = 1'b0;
      if (ack0 || ack1) k++;
      @(negedge clk);
      #1;
    end
    check("abort_no_ack", k, 32'd0);
    check("abort_bytes", {mem[8], mem[9], mem[10], mem[11]}, 32'hDE00_0000);
    access(1'b0, 1'b0, 32'd11, 32'h0, lat, rd, t0, hs_ok);
    check("post_abort_latency", lat, 32'd6);
    check("post_abort_rdata", rd, 32'hDE00_0000);

    // Randomized traffic against the word-level model.
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    for (int i = 0; i < 1024; i++) ref_mem[i] = mem[i];
    last_g = 1'b1;
    for (int r = 0; r < 40; r++) begin
      k = $urandom_range(1, 3);
      sel0 = k[0]; sel1 = k[1];
      for (int p = 0; p < 2; p++) begin
        rwe[p] = 1'($urandom_range(0, 1));
        raddr[p] = $urandom();
        rdat[p] = $urandom();
      end
      if (sel0 && sel1) begin order[0] = ~last_g; order[1] = last_g; nexp = 2; end
      else begin order[0] = sel1; order[1] = sel1; nexp = 1; end
      @(negedge clk);
      req0 = sel0; we0 = rwe[0]; addr0 = raddr[0]; wdata0 = rdat[0];
      req1 = sel1; we1 = rwe[1]; addr1 = raddr[1]; wdata1 = rdat[1];
      k = 0;
      for (int n = 0; n < 24; n++) begin
        #1;
        if (ack0 && ack1) check("rnd_dual_ack", 32'd1, 32'd0);
        for (int p = 0; p < 2; p++) begin
          if ((p == 0 ? ack0 : ack1) && k < nexp) begin
            check($sformatf("rnd%0d_port", r), p, {31'd0, order[k]});
            check($sformatf("rnd%0d_latency", r), n, 6 + 7*k);
            if (rwe[p]) ref_write(raddr[p], rdat[p]);
            else check($sformatf("rnd%0d_rdata", r), rdata, ref_read(raddr[p]));
            if (p == 0) req0 = 1'b0; else req1 = 1'b0;
            k++;
          end
        end
        if (k == nexp) break;
        @(negedge clk);
      end
      if (k != nexp) check($sformatf("rnd%0d_timeout", r), k, nexp);
      req0 = 1'b0; req1 = 1'b0;
      last_g = order[nexp-1];
    end
    repeat (3) @(negedge clk);
    mism = 0;
    for (int i = 0; i < 1024; i++) if (mem[i] != ref_mem[i]) mism++;
    check("rnd_mem_image", mism, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
